// File: rtl/div_unit.sv
// Iterative 32-bit radix-2 restoring divider (DIV/DIVU) for the execute stage.
// Produces {remainder, quotient} after 32 steps and stalls the pipeline while busy.
module div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        signed_div,
    input  logic        start,
    input  logic        annul,
    input  logic        hold,
    output logic [63:0] result,
    output logic        ready,
    output logic        stall_divE
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t      r_state;
    logic [31:0] r_rem;
    logic [31:0] r_quo;
    logic [31:0] r_divisor;
    logic        r_qneg;
    logic        r_rneg;
    logic [5:0]  r_cnt;
    logic [63:0] r_result;
    logic        r_ready;

    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [32:0] w_partial;
    logic [32:0] w_diff;
    logic        w_ge;
    logic [31:0] w_rem_next;
    logic [31:0] w_quo_next;
    logic [31:0] w_q_final;
    logic [31:0] w_r_final;

    assign w_abs_a = (signed_div && a[31]) ? (~a + 32'd1) : a;
    assign w_abs_b = (signed_div && b[31]) ? (~b + 32'd1) : b;

    // r_quo starts as the dividend magnitude; its MSB feeds each step while
    // quotient bits shift in at the bottom.
    assign w_partial  = {r_rem, r_quo[31]};
    assign w_diff     = w_partial - {1'b0, r_divisor};
    assign w_ge       = (w_partial >= {1'b0, r_divisor});
    assign w_rem_next = w_ge ? w_diff[31:0] : w_partial[31:0];
    assign w_quo_next = {r_quo[30:0], w_ge};

    assign w_q_final  = r_qneg ? (~w_quo_next + 32'd1) : w_quo_next;
    assign w_r_final  = r_rneg ? (~w_rem_next + 32'd1) : w_rem_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_rem     <= '0;
            r_quo     <= '0;
            r_divisor <= '0;
            r_qneg    <= 1'b0;
            r_rneg    <= 1'b0;
            r_cnt     <= '0;
            r_result  <= '0;
            r_ready   <= 1'b0;
        end else if (annul) begin
            r_state <= IDLE;
            r_ready <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_rem     <= '0;
                        r_quo     <= w_abs_a;
                        r_divisor <= w_abs_b;
                        r_qneg    <= signed_div & (a[31] ^ b[31]);
                        r_rneg    <= signed_div & a[31];
                        r_cnt     <= '0;
                        r_state   <= BUSY;
                    end
                end
                BUSY: begin
                    r_rem <= w_rem_next;
                    r_quo <= w_quo_next;
                    r_cnt <= r_cnt + 6'd1;
                    if (r_cnt == 6'd31) begin
                        r_result <= {w_r_final, w_q_final};
                        r_ready  <= 1'b1;
                        r_state  <= DONE;
                    end
                end
                DONE: begin
                    if (!hold) begin
                        r_ready <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_ready <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign result     = r_result;
    assign ready      = r_ready;
    assign stall_divE = ((r_state == IDLE) && start && !annul) ||
                        ((r_state == BUSY) && !annul);

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: timing, sign rules, divide-by-zero,
// annul, hold in DONE, back-to-back issue and asynchronous reset.
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic        signed_div;
    logic        start;
    logic        annul;
    logic        hold;
    logic [63:0] result;
    logic        ready;
    logic        stall_divE;

    int unsigned checks;
    int unsigned errors;

    div_unit dut (
        .clk        (clk),
        .rst        (rst),
        .a          (a),
        .b          (b),
        .signed_div (signed_div),
        .start      (start),
        .annul      (annul),
        .hold       (hold),
        .result     (result),
        .ready      (ready),
        .stall_divE (stall_divE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Issues one division from IDLE and checks the 33-cycle stall and result.
    task automatic run_div(input logic [31:0] ia, input logic [31:0] ib, input logic sgn,
                           input logic [63:0] exp, input string tag, input logic leave);
        int n;
        a = ia;
        b = ib;
        signed_div = sgn;
        start = 1'b1;
        #1;
        check({tag, "_stall_c0"}, {63'd0, stall_divE}, 64'd1);
        check({tag, "_ready_c0"}, {63'd0, ready}, 64'd0);
        n = 0;
        while (stall_divE === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        check({tag, "_stall_cycles"}, 64'(n), 64'd33);
        check({tag, "_ready"}, {63'd0, ready}, 64'd1);
        check({tag, "_result"}, result, exp);
        if (leave) begin
            tick();
            start = 1'b0;
            #1;
            check({tag, "_ready_after"}, {63'd0, ready}, 64'd0);
        end
    endtask

    initial begin
        int bad;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        a = '0;
        b = '0;
        signed_div = 1'b0;
        start = 1'b0;
        annul = 1'b0;
        hold = 1'b0;

        tick();
        tick();
        check("reset_result", result, 64'd0);
        check("reset_ready", {63'd0, ready}, 64'd0);
        check("reset_stall", {63'd0, stall_divE}, 64'd0);
        rst = 1'b0;
        tick();

        run_div(32'd100, 32'd7, 1'b0, {32'h00000002, 32'h0000000E}, "divu_100_7", 1'b1);
        run_div(32'hFFFFFFF9, 32'd2, 1'b1, {32'hFFFFFFFF, 32'hFFFFFFFD}, "div_m7_2", 1'b1);
        run_div(32'h80000000, 32'hFFFFFFFF, 1'b1, {32'h00000000, 32'h80000000}, "div_ovf", 1'b1);
        run_div(32'd7, 32'd0, 1'b0, {32'h00000007, 32'hFFFFFFFF}, "divu_by0", 1'b1);

        // Annul in BUSY cycle 10.
        a = 32'd50;
        b = 32'd5;
        signed_div = 1'b0;
        start = 1'b1;
        #1;
        check("annul_stall_c0", {63'd0, stall_divE}, 64'd1);
        for (int i = 0; i < 10; i++) tick();
        check("annul_stall_c10_pre", {63'd0, stall_divE}, 64'd1);
        annul = 1'b1;
        #1;
        check("annul_stall_drop", {63'd0, stall_divE}, 64'd0);
        tick();
        annul = 1'b0;
        start = 1'b0;
        #1;
        check("annul_idle_stall", {63'd0, stall_divE}, 64'd0);
        check("annul_result_kept", result, {32'h00000007, 32'hFFFFFFFF});
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            if (ready !== 1'b0) bad++;
            tick();
        end
        check("annul_ready_never", 64'(bad), 64'd0);
        check("annul_result_kept2", result, {32'h00000007, 32'hFFFFFFFF});

        // Hold asserted throughout, including BUSY, then 5 cycles in DONE.
        hold = 1'b1;
        run_div(32'd100, 32'hFFFFFFF9, 1'b1, {32'h00000002, 32'hFFFFFFF2}, "div_hold", 1'b0);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (ready !== 1'b1 || stall_divE !== 1'b0) bad++;
        end
        check("hold_ready_6cyc", 64'(bad), 64'd0);
        hold = 1'b0;
        #1;
        check("hold_result_stable", result, {32'h00000002, 32'hFFFFFFF2});
        tick();
        // Back-to-back: next DIV issued in the IDLE cycle right after DONE.
        run_div(32'hFFFFFFEC, 32'd6, 1'b1, {32'hFFFFFFFE, 32'hFFFFFFFD}, "div_b2b", 1'b1);

        // Asynchronous reset in BUSY cycle 20.
        a = 32'd1000;
        b = 32'd3;
        signed_div = 1'b0;
        start = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        check("rst_busy_stall", {63'd0, stall_divE}, 64'd1);
        #2;
        rst = 1'b1;
        start = 1'b0;
        #1;
        check("rst_async_result", result, 64'd0);
        check("rst_async_ready", {63'd0, ready}, 64'd0);
        check("rst_async_stall", {63'd0, stall_divE}, 64'd0);
        tick();
        rst = 1'b0;
        tick();
        run_div(32'd9, 32'd3, 1'b0, {32'h00000000, 32'h00000003}, "divu_9_3", 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
